mole_scheduler: RTL and testbench
=================================

// Module: mole_scheduler
// PURPOSE
//  In-game controller for the whack-a-mole board. Decides when and where moles appear,
//  ages each mole, and judges switch toggles as hits or wrong whacks.
//  Drives the 16 LEDs and sends per-cycle hit/escape events to the score and game-state logic.
//  Runs on the system clock; the game-rate tick (1/2/5 Hz, chosen by mode) arrives as a one-cycle enable.
// PARAMETERS
//  NUM_HOLES       16       holes/LEDs/switches; 2..16
//  MAX_ACTIVE      3        max simultaneously lit moles; 1..NUM_HOLES
//  LIFETIME        4        ticks a mole stays lit before escaping; >=1
//  SPAWN_INTERVAL  2        ticks between spawn attempts; >=1
//  LFSR_SEED       16'hACE1 reset value of position LFSR; must be nonzero
// PORTS
//  clock_i       in   1          system clock
//  reset_i       in   1          synchronous, active-low reset
//  tick_i        in   1          one-cycle game-rate pulse
//  enable_i      in   1          1 = game in play (game_state==01 upstream)
//  switches_i    in   NUM_HOLES  raw board switches, already synchronised
//  moles_o       out  NUM_HOLES  lit moles (LED drive)
//  hits_o        out  5          holes whacked this cycle, 0..NUM_HOLES; valid one cycle
//  escape_o      out  1          >=1 mole expired this cycle (one-cycle pulse)
//  wrong_o       out  1          toggle on an unlit hole this cycle (one-cycle pulse)
//  active_cnt_o  out  5          popcount(moles_o)
// BEHAVIOUR
//  Reset (reset_i==0 at posedge): state=IDLE, moles_o=0, hits_o=0, escape_o=0, wrong_o=0,
//   lifetime counters=0, spawn counter=0, LFSR=LFSR_SEED, switch history=switches_i.
//  FSM: IDLE -(enable_i)-> RUN; RUN -(!enable_i)-> FLUSH; FLUSH -> IDLE (always, 1 cycle).
//   FLUSH clears all moles and counters and emits no escape. IDLE: moles_o=0; switches tracked, not judged.
//  LFSR: 16-bit Galois, mask 16'hB400, steps every cycle in every state.
//  Toggle detect (RUN only): t = switches_i ^ sw_q; sw_q <= switches_i every cycle.
//   Either direction counts as a whack.
//  Hit: t[k] & moles_o[k] -> clear hole k next cycle; hits_o = popcount of such k (registered, 1 cycle).
//  Wrong: any t[k] & ~moles_o[k] -> wrong_o=1 next cycle.
//  Aging (RUN, tick_i): each lit hole's counter decrements; counter==1 on tick -> hole cleared,
//   escape_o=1 next cycle.
//  Spawn (RUN, tick_i): spawn counter increments and wraps at SPAWN_INTERVAL.
//   On wrap, if active_cnt_o < MAX_ACTIVE: start = LFSR[3:0] % NUM_HOLES.
//   Probe start, start+1, ... (mod NUM_HOLES) for the first hole unlit in the current moles_o.
//   Light it with counter=LIFETIME. At most one spawn per tick. A full board skips the attempt;
//   the counter still wraps.
//  Priority, same cycle same hole: hit > expire (whack on the last tick scores).
//   Spawn uses pre-update occupancy, so a hole cleared this cycle cannot be respawned until the
//   next attempt. A toggle on the hole being spawned is judged against the old value (wrong).
//  Latency: switch toggle -> moles_o clear + hits_o = 1 cycle; tick -> spawn/expire = 1 cycle.
//  Reset mid-RUN overrides all; no events emitted in the reset cycle or the cycle after.
// CONFIGURATION
//  SPEEDUP_EN defined: cumulative hits are counted (saturating, 8 bit).
//   Effective spawn interval = max(1, SPAWN_INTERVAL - hits/8).
//   Cleared on reset and in FLUSH.
//  SPEEDUP_EN undefined: interval fixed at SPAWN_INTERVAL; no hit accumulator is synthesised.
// TESTING
//  1. Hold reset_i=0 3 cycles -> moles_o=0, hits_o=0, escape_o=0, wrong_o=0;
//     release with enable_i=0 -> moles_o stays 0.
//  2. enable_i=1, 2 ticks (SPAWN_INTERVAL=2) -> exactly one bit of moles_o set one cycle after the
//     2nd tick; active_cnt_o=1.
//  3. Toggle the switch of the lit hole -> next cycle that bit is 0, hits_o=1, wrong_o=0;
//     toggle an unlit hole -> wrong_o=1, hits_o=0.
//  4. Leave one mole untouched for 4 ticks -> cleared one cycle after the 4th tick, escape_o=1 for
//     exactly 1 cycle. Toggle on the 4th-tick cycle instead -> hits_o=1, escape_o=0.
//  5. Force LFSR start onto lit holes with MAX_ACTIVE=3 -> probe picks the next free hole with wrap
//     (start=15 lit -> hole 0); never more than 3 lit; 4th attempt skipped.
//  6. Drop enable_i with 3 moles lit -> FLUSH: moles_o=0 next cycle, escape_o=0, then IDLE;
//     with SPEEDUP_EN, after 8 hits new spawns occur every tick.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole in-game controller: spawns, ages and judges moles on a 16-hole board.
// Optional SPEEDUP_EN: cumulative hit count shortens the spawn interval.
module mole_scheduler #(
  parameter int unsigned NUM_HOLES      = 16,
  parameter int unsigned MAX_ACTIVE     = 3,
  parameter int unsigned LIFETIME       = 4,
  parameter int unsigned SPAWN_INTERVAL = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic                 enable_i,
  input  logic [NUM_HOLES-1:0] switches_i,
  output logic [NUM_HOLES-1:0] moles_o,
  output logic [4:0]           hits_o,
  output logic                 escape_o,
  output logic                 wrong_o,
  output logic [4:0]           active_cnt_o
);

  localparam int unsigned HW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
  localparam int unsigned CW = $clog2(LIFETIME + 1);
  localparam int unsigned SW = $clog2(SPAWN_INTERVAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [NUM_HOLES-1:0]   moles_q, moles_d;
  logic [NUM_HOLES-1:0]   sw_q, sw_d;
  logic [CW-1:0]          cnt_q [NUM_HOLES];
  logic [CW-1:0]          cnt_d [NUM_HOLES];
  logic [SW-1:0]          spawn_q, spawn_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [4:0]             hits_q, hits_d;
  logic                   escape_q, escape_d;
  logic                   wrong_q, wrong_d;
  logic [4:0]             active_q, active_d;

  logic [NUM_HOLES-1:0]   tog, hit_vec;
  logic [HW-1:0]          pick;
  logic                   found;
  int unsigned            start, probe_pos, interval;

`ifdef SPEEDUP_EN
  logic [7:0]             acc_q, acc_d;
  logic [8:0]             acc_sum;
`endif

  function automatic logic [4:0] popcnt(input logic [NUM_HOLES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < NUM_HOLES; k++) c = c + 5'(v[k]);
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    moles_d  = moles_q;
    cnt_d    = cnt_q;
    spawn_d  = spawn_q;
    sw_d     = switches_i;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    hits_d   = '0;
    escape_d = 1'b0;
    wrong_d  = 1'b0;
    tog      = switches_i ^ sw_q;
    hit_vec  = tog & moles_q;
    start    = 32'(lfsr_q[3:0]) % NUM_HOLES;
    probe_pos = 0;
    found    = 1'b0;
    pick     = '0;
`ifdef SPEEDUP_EN
    acc_d    = acc_q;
    acc_sum  = '0;
    interval = (SPAWN_INTERVAL > 32'(acc_q[7:3])) ? SPAWN_INTERVAL - 32'(acc_q[7:3]) : 1;
`else
    interval = SPAWN_INTERVAL;
`endif

    // First free hole at or after start, judged on pre-update occupancy
    for (int i = 0; i < NUM_HOLES; i++) begin
      probe_pos = start + 32'(i);
      if (probe_pos >= NUM_HOLES) probe_pos = probe_pos - NUM_HOLES;
      if (!found && !moles_q[HW'(probe_pos)]) begin
        found = 1'b1;
        pick  = HW'(probe_pos);
      end
    end

    case (state_q)
      S_IDLE: begin
        moles_d = '0;
        if (enable_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable_i) begin
          state_d = S_FLUSH;
          moles_d = '0;
          spawn_d = '0;
          for (int k = 0; k < NUM_HOLES; k++) cnt_d[k] = '0;
        end else begin
          for (int k = 0; k < NUM_HOLES; k++) begin
            if (hit_vec[k]) begin
              moles_d[k] = 1'b0;
              cnt_d[k]   = '0;
            end else if (tick_i && moles_q[k]) begin
              if (cnt_q[k] == CW'(1)) begin
                moles_d[k] = 1'b0;
                cnt_d[k]   = '0;
                escape_d   = 1'b1;
              end else begin
                cnt_d[k] = cnt_q[k] - CW'(1);
              end
            end
          end
          hits_d  = popcnt(hit_vec);
          wrong_d = |(tog & ~moles_q);
          if (tick_i) begin
            if (32'(spawn_q) + 32'd1 >= interval) begin
              spawn_d = '0;
              if (active_q < 5'(MAX_ACTIVE) && found) begin
                moles_d[pick] = 1'b1;
                cnt_d[pick]   = CW'(LIFETIME);
              end
            end else begin
              spawn_d = spawn_q + SW'(1);
            end
          end
`ifdef SPEEDUP_EN
          acc_sum = 9'(acc_q) + 9'(hits_d);
          acc_d   = acc_sum[8] ? 8'hFF : acc_sum[7:0];
`endif
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        moles_d = '0;
        spawn_d = '0;
        for (int k = 0; k < NUM_HOLES; k++) cnt_d[k] = '0;
`ifdef SPEEDUP_EN
        acc_d = '0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    active_d = popcnt(moles_d);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      moles_q  <= '0;
      sw_q     <= switches_i;
      spawn_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      hits_q   <= '0;
      escape_q <= 1'b0;
      wrong_q  <= 1'b0;
      active_q <= '0;
      for (int k = 0; k < NUM_HOLES; k++) cnt_q[k] <= '0;
`ifdef SPEEDUP_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      moles_q  <= moles_d;
      sw_q     <= sw_d;
      spawn_q  <= spawn_d;
      lfsr_q   <= lfsr_d;
      hits_q   <= hits_d;
      escape_q <= escape_d;
      wrong_q  <= wrong_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
`ifdef SPEEDUP_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign moles_o      = moles_q;
  assign hits_o       = hits_q;
  assign escape_o     = escape_q;
  assign wrong_o      = wrong_q;
  assign active_cnt_o = active_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler: two configurations driven in lockstep against a
// per-hole age/occupancy reference model.
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, tick, en;
  logic [15:0] sw;

  logic [15:0] moles_a, moles_b;
  logic [4:0]  hits_a, hits_b, act_a, act_b;
  logic        esc_a, esc_b, wrg_a, wrg_b;

  always #5 clk = ~clk;

  mole_scheduler u_dut_a (
    .clock_i(clk), .reset_i(rst_n), .tick_i(tick), .enable_i(en), .switches_i(sw),
    .moles_o(moles_a), .hits_o(hits_a), .escape_o(esc_a), .wrong_o(wrg_a), .active_cnt_o(act_a)
  );

  mole_scheduler #(.NUM_HOLES(16), .MAX_ACTIVE(3), .LIFETIME(9), .SPAWN_INTERVAL(1)) u_dut_b (
    .clock_i(clk), .reset_i(rst_n), .tick_i(tick), .enable_i(en), .switches_i(sw),
    .moles_o(moles_b), .hits_o(hits_b), .escape_o(esc_b), .wrong_o(wrg_b), .active_cnt_o(act_b)
  );

  typedef struct {
    int          st;       // 0 idle, 1 running, 2 flushing
    logic [15:0] moles;
    int          age [16];
    int          spawn;
    logic [15:0] lfsr;
    logic [15:0] sw;
    int          hits;
    bit          esc;
    bit          wrong;
    int          acc;
  } mdl_t;

  mdl_t m [2];
  int   p_life [2] = '{4, 9};
  int   p_si   [2] = '{2, 1};
  int   p_max  [2] = '{3, 3};

  int n_cmp = 0;
  int n_err = 0;
  int n_hit_seen = 0, n_esc_seen = 0, n_full_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pop16(input logic [15:0] v);
    int c = 0;
    for (int k = 0; k < 16; k++) if (v[k]) c++;
    return c;
  endfunction

  function automatic int pick_lit(input logic [15:0] v);
    int s = $urandom_range(0, 15);
    for (int j = 0; j < 16; j++) if (v[(s + j) % 16]) return (s + j) % 16;
    return -1;
  endfunction

  task automatic clear_board(input int i);
    m[i].moles = '0;
    m[i].spawn = 0;
    for (int k = 0; k < 16; k++) m[i].age[k] = 0;
  endtask

  // Advance model i by one clock using the currently driven inputs
  task automatic mstep(input int i);
    logic [15:0] old;
    int interval, p;
    bit lsb;
    if (!rst_n) begin
      m[i].st = 0; clear_board(i);
      m[i].lfsr = 16'hACE1; m[i].sw = sw;
      m[i].hits = 0; m[i].esc = 0; m[i].wrong = 0; m[i].acc = 0;
      return;
    end
    m[i].hits = 0; m[i].esc = 0; m[i].wrong = 0;
    old = m[i].moles;
    if (m[i].st == 0) begin
      m[i].moles = '0;
      if (en) m[i].st = 1;
    end else if (m[i].st == 2) begin
      clear_board(i); m[i].acc = 0; m[i].st = 0;
    end else if (!en) begin
      clear_board(i); m[i].st = 2;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (sw[k] != m[i].sw[k]) begin
          if (old[k]) begin m[i].hits++; m[i].moles[k] = 1'b0; m[i].age[k] = 0; end
          else m[i].wrong = 1;
        end else if (old[k] && tick) begin
          if (m[i].age[k] == 1) begin m[i].moles[k] = 1'b0; m[i].age[k] = 0; m[i].esc = 1; end
          else m[i].age[k]--;
        end
      end
      if (tick) begin
        interval = p_si[i];
`ifdef SPEEDUP_EN
        interval = p_si[i] - m[i].acc / 8;
        if (interval < 1) interval = 1;
`endif
        m[i].spawn++;
        if (m[i].spawn >= interval) begin
          m[i].spawn = 0;
          if (pop16(old) < p_max[i]) begin
            p = m[i].lfsr % 16;
            while (old[p]) p = (p + 1) % 16;
            m[i].moles[p] = 1'b1;
            m[i].age[p] = p_life[i];
          end
        end
      end
      m[i].acc = m[i].acc + m[i].hits;
      if (m[i].acc > 255) m[i].acc = 255;
    end
    m[i].sw = sw;
    lsb = m[i].lfsr[0];
    m[i].lfsr = m[i].lfsr >> 1;
    if (lsb) m[i].lfsr = m[i].lfsr ^ 16'hB400;
  endtask

  task automatic check_all();
    chk("a.moles",  32'(moles_a), 32'(m[0].moles));
    chk("a.hits",   32'(hits_a),  32'(m[0].hits));
    chk("a.escape", 32'(esc_a),   32'(m[0].esc));
    chk("a.wrong",  32'(wrg_a),   32'(m[0].wrong));
    chk("a.active", 32'(act_a),   32'(pop16(m[0].moles)));
    chk("b.moles",  32'(moles_b), 32'(m[1].moles));
    chk("b.hits",   32'(hits_b),  32'(m[1].hits));
    chk("b.escape", 32'(esc_b),   32'(m[1].esc));
    chk("b.wrong",  32'(wrg_b),   32'(m[1].wrong));
    chk("b.active", 32'(act_b),   32'(pop16(m[1].moles)));
    if (m[0].hits > 0 || m[1].hits > 0) n_hit_seen++;
    if (m[0].esc || m[1].esc) n_esc_seen++;
    if (pop16(m[1].moles) == 3) n_full_seen++;
  endtask

  initial begin
    int r, h;
    rst_n = 1'b0;
    en    = 1'b0;
    tick  = 1'b0;
    sw    = 16'($urandom);
    mstep(0); mstep(1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_all();
      rst_n = (cyc >= 2) && ($urandom_range(0, 599) != 0);
      if (cyc < 10) en = 1'b0;
      else if (cyc == 10) en = 1'b1;
      else if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 11);
      if (r == 0 || r == 1) begin
        h = pick_lit(m[0].moles);
        if (h >= 0) sw[h] = ~sw[h];
      end else if (r == 2) begin
        h = pick_lit(m[1].moles);
        if (h >= 0) sw[h] = ~sw[h];
      end else if (r == 3) begin
        h = $urandom_range(0, 15);
        sw[h] = ~sw[h];
      end
      mstep(0); mstep(1);
    end
    @(negedge clk);
    check_all();
    chk("hit_events_seen",    32'(n_hit_seen > 0),  32'd1);
    chk("escape_events_seen", 32'(n_esc_seen > 0),  32'd1);
    chk("full_board_seen",    32'(n_full_seen > 0), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
